md5_candidate_enum: RTL and testbench
=====================================

Name: md5_candidate_enum

Overview:
- Parametrised candidate generator for the MD5 brute-force engine. It is the next generation of the fixed-depth per-symbol iterator.
- It enumerates every string of N_SYMB characters in the range [FROM_CHAR..TO_CHAR] as a single odometer. Each candidate is written into a caller-supplied 512-bit pre-padded MD5 block.
- Candidates stream to one MD5 hash-check core over a valid/ready handshake.
- Multi-core partitioning is done through LANE_ID/NUM_LANES. Match reporting, abort and candidate counting are built in.

Parameters:
- N_SYMB, 4, number of enumerated character positions (1..16)
- SYMB_BASE, 0, byte index in the block of position 0 (SYMB_BASE+N_SYMB <= 64)
- FROM_CHAR, 8'h20, first character code (inclusive)
- TO_CHAR, 8'h7E, last character code (inclusive, >= FROM_CHAR)
- NUM_LANES, 1, number of parallel enumerators sharing the keyspace
- LANE_ID, 0, this lane's index (0..NUM_LANES-1)
- CNT_W, 32, width of the candidate counter

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  pulse: latch template, begin enumeration (honoured in IDLE, DONE, FOUND)
- abort  in  1  pulse: stop and return to IDLE
- start_str  in  512  template block, padding and length already set; sampled on start
- cand_valid  out  1  cand_str holds a valid candidate
- cand_ready  in  1  downstream accepts the candidate
- cand_str  out  512  template with the N_SYMB positions overwritten
- match_in  in  1  checker reports a hash match (one-cycle pulse)
- match_str  in  512  matching block, valid with match_in
- busy  out  1  state is RUN
- done  out  1  keyspace exhausted, no match (level, until next start/abort)
- find_str  out  1  match found (level, until next start/abort)
- result_str  out  512  latched match_str
- cand_count  out  CNT_W  accepted candidates since last start, saturating

Behaviour:
- Byte layout: block byte b occupies bits [8b+7:8b]. Position p is byte SYMB_BASE+p. All other bytes are passed through from the latched template.
- Reset (async, reset_n=0): state IDLE. All outputs are 0, including cand_str, result_str and cand_count. All digits are cleared.
- States:
  - IDLE, DONE, FOUND: start -> RUN. This latches start_str, clears cand_count/done/find_str, and loads the digits.
  - Digit load: digit 0 = FROM_CHAR+LANE_ID; digits 1..N-1 = FROM_CHAR.
  - If FROM_CHAR+LANE_ID > TO_CHAR (empty lane), start -> DONE directly: done=1 next cycle, cand_valid never asserted.
  - RUN: cand_valid=1 from the cycle after start, with the first candidate.
- Handshake: an accept is cand_valid && cand_ready. With no accept, cand_str and cand_valid hold stable. After an accept, the next candidate appears the following cycle, and valid stays high, giving 1 candidate/cycle at full throughput.
- Odometer advance, per accept:
  - Digit 0 += NUM_LANES. If the result is > TO_CHAR (compare at 9 bits, no 8-bit wrap), it reloads FROM_CHAR+LANE_ID and carries.
  - Digit k>0 += 1 on carry-in. If > TO_CHAR it reloads FROM_CHAR and carries.
  - Carry out of digit N_SYMB-1 on an accept means the last candidate was just accepted: RUN -> DONE, cand_valid=0 next cycle, done=1.
- cand_count: +1 per accept. Saturates at all-ones.
- match_in:
  - In RUN: -> FOUND next cycle, result_str<=match_str, find_str=1, cand_valid=0. This is the only legal withdrawal of valid without an accept.
  - In DONE (late match from pipeline): -> FOUND, done=0, find_str=1, result_str latched.
  - Ignored in IDLE and FOUND; the first match wins.
- abort: any state -> IDLE next cycle. Clears valid/done/find_str; keeps cand_count and result_str.
- Priority in one cycle: abort > match_in > accept/advance. start is ignored in RUN. If start and abort coincide, abort wins.
- The accept on the same cycle as match_in still counts toward cand_count.
- busy = (state==RUN).

Decomposition:
- Package md5_bf_pkg:
  - BLOCK_W=512 and char_t (logic[7:0]).
  - enum enum_state_t {IDLE, RUN, DONE, FOUND}.
  - Helper function for byte insertion at index.
- Sub-module symbol_digit: one odometer digit. It takes load, inc, step, load value and TO_CHAR, and outputs the char and carry. It is instantiated N_SYMB times via generate with a chained carry.

Test Plan:
1. N_SYMB=2, FROM='a', TO='c', SYMB_BASE=0, ready=1, start -> 9 candidates in order "aa","ba","ca","ab",…,"cc" on consecutive cycles, then done=1, cand_count=9, template bytes 2..63 unchanged.
2. Same config, cand_ready low 3 cycles on the 2nd candidate -> cand_str holds "ba" and valid stays 1 for 3 cycles. The total is still 9 and the order is unchanged.
3. NUM_LANES=2, LANE_ID=1, N_SYMB=1, range 'a'..'c' -> exactly one candidate "b", count=1, done. With NUM_LANES=4, LANE_ID=3 -> done 1 cycle after start, count 0, valid never high.
4. Default params, match_in pulsed with match_str=0xDEAD… after 5 accepts -> next cycle find_str=1, result_str=0xDEAD…, cand_valid=0, count=5. A second match_in is ignored.
5. abort during RUN after 4 accepts -> IDLE, valid=0, count stays 4. Re-start -> first candidate "    " (4×0x20) again, count cleared.
6. reset_n asserted mid-RUN, asynchronously between clock edges -> all outputs 0 immediately. After release, no activity until start.

Source files
------------

// File: rtl/md5_bf_pkg.sv
// rtl/md5_bf_pkg.sv - shared types and helpers for the MD5 candidate generator
// Purpose: block width, character type, enumerator state encoding and a
//          byte-insertion helper used when building candidate blocks.
// Ports:   none (package).
package md5_bf_pkg;

  localparam int BLOCK_W = 512;

  typedef logic [7:0] char_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE, FOUND} enum_state_t;

  // Returns blk with byte idx (bits [8*idx+7:8*idx]) replaced by ch.
  function automatic logic [BLOCK_W-1:0] put_byte(input logic [BLOCK_W-1:0] blk,
                                                  input int idx,
                                                  input char_t ch);
    logic [BLOCK_W-1:0] r;
    r = blk;
    r[8*idx +: 8] = ch;
    return r;
  endfunction

endpackage

// File: rtl/md5_candidate_enum_symbol_digit.sv
// rtl/md5_candidate_enum_symbol_digit.sv - one odometer digit of the candidate enumerator
// Purpose: holds one character position; loads a start value, advances by
//          step on inc and wraps back to load_val with a carry past to_char.
// Ports:   clk, reset_n    - clock, async active-low reset (clears the digit)
//          load, load_val  - load the digit (also the wrap-around value)
//          inc, step       - advance request and increment size
//          to_char         - last legal character code
//          ch, carry       - current character, carry-out (combinational)
module symbol_digit
  import md5_bf_pkg::*;
(
  input  logic  clk,
  input  logic  reset_n,
  input  logic  load,
  input  logic  inc,
  input  char_t step,
  input  char_t load_val,
  input  char_t to_char,
  output char_t ch,
  output logic  carry
);

  // Nine-bit sum so a step that crosses 8'hFF still reads as overflow.
  logic [8:0] sum;

  assign sum   = {1'b0, ch} + {1'b0, step};
  assign carry = inc && (sum > {1'b0, to_char});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ch <= '0;
    end else if (load) begin
      ch <= load_val;
    end else if (inc) begin
      ch <= carry ? load_val : sum[7:0];
    end
  end

endmodule

// File: rtl/md5_candidate_enum.sv
// rtl/md5_candidate_enum.sv - odometer candidate generator feeding one MD5 check core
// Purpose: enumerates every N_SYMB-character string over [FROM_CHAR..TO_CHAR]
//          (digit 0 fastest, striped across NUM_LANES lanes) into a template
//          block and streams candidates over a valid/ready handshake.
// Ports:   clk, reset_n            - clock, async active-low reset
//          start, start_str        - begin enumeration with template block
//          abort                   - return to IDLE
//          cand_valid/ready/str    - candidate stream
//          match_in, match_str     - match report from the check core
//          busy, done, find_str    - status levels
//          result_str, cand_count  - latched match, accepted-candidate count
module md5_candidate_enum
  import md5_bf_pkg::*;
#(
  parameter int    N_SYMB    = 4,
  parameter int    SYMB_BASE = 0,
  parameter char_t FROM_CHAR = 8'h20,
  parameter char_t TO_CHAR   = 8'h7E,
  parameter int    NUM_LANES = 1,
  parameter int    LANE_ID   = 0,
  parameter int    CNT_W     = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [BLOCK_W-1:0] start_str,
  output logic               cand_valid,
  input  logic               cand_ready,
  output logic [BLOCK_W-1:0] cand_str,
  input  logic               match_in,
  input  logic [BLOCK_W-1:0] match_str,
  output logic               busy,
  output logic               done,
  output logic               find_str,
  output logic [BLOCK_W-1:0] result_str,
  output logic [CNT_W-1:0]   cand_count
);

  // First character of this lane; a lane starting past TO_CHAR owns nothing.
  localparam logic [8:0] LANE_FIRST9 = 9'(FROM_CHAR) + 9'(LANE_ID);
  localparam bit         EMPTY_LANE  = LANE_FIRST9 > {1'b0, TO_CHAR};
  localparam char_t      LANE_FIRST  = LANE_FIRST9[7:0];
  localparam char_t      LANE_STEP   = 8'(NUM_LANES);

  enum_state_t        state;
  logic [BLOCK_W-1:0] template_str;
  char_t              digit [N_SYMB];
  logic [N_SYMB:0]    carry;
  logic               accept, advance, match_take, start_take, last_carry;

  assign accept     = cand_valid && cand_ready;
  assign advance    = accept && !abort;
  assign match_take = match_in && ((state == RUN) || (state == DONE));
  // A late match in DONE outranks a simultaneous start.
  assign start_take = start && !abort && (state != RUN) && !match_take;
  assign last_carry = carry[N_SYMB];
  assign carry[0]   = advance;

  for (genvar p = 0; p < N_SYMB; p++) begin : g_digit
    symbol_digit u_digit (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (start_take),
      .inc      (carry[p]),
      .step     ((p == 0) ? LANE_STEP : 8'd1),
      .load_val ((p == 0) ? LANE_FIRST : FROM_CHAR),
      .to_char  (TO_CHAR),
      .ch       (digit[p]),
      .carry    (carry[p+1])
    );
  end

  always_comb begin
    cand_str = template_str;
    for (int p = 0; p < N_SYMB; p++) begin
      cand_str = put_byte(cand_str, SYMB_BASE + p, digit[p]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cand_valid   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      find_str     <= 1'b0;
      template_str <= '0;
      result_str   <= '0;
    end else if (abort) begin
      state      <= IDLE;
      cand_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      find_str   <= 1'b0;
    end else if (match_take) begin
      state      <= FOUND;
      result_str <= match_str;
      cand_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      find_str   <= 1'b1;
    end else if (start_take) begin
      template_str <= start_str;
      find_str     <= 1'b0;
      if (EMPTY_LANE) begin
        state      <= DONE;
        cand_valid <= 1'b0;
        busy       <= 1'b0;
        done       <= 1'b1;
      end else begin
        state      <= RUN;
        cand_valid <= 1'b1;
        busy       <= 1'b1;
        done       <= 1'b0;
      end
    end else if (accept && last_carry) begin
      state      <= DONE;
      cand_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cand_count <= '0;
    end else if (start_take) begin
      cand_count <= '0;
    end else if (advance && (cand_count != '1)) begin
      cand_count <= cand_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_md5_candidate_enum.sv
// tb/tb_md5_candidate_enum.sv - self-checking bench for md5_candidate_enum
module tb_md5_candidate_enum;
  localparam int BW = 512;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0, abort = 1'b0, cand_ready = 1'b0, match_in = 1'b0;
  logic [BW-1:0] start_str = '0, match_str = '0;

  always #5 clk = ~clk;

  // m_: N=2 'a'..'c' (fully modelled), d_: defaults, a_: lane 1 of 2,
  // b_: empty lane 3 of 4, s_: main config with a 3-bit counter.
  logic m_valid, m_busy, m_done, m_find; logic [BW-1:0] m_cand, m_res; logic [31:0] m_cnt;
  logic d_valid, d_busy, d_done, d_find; logic [BW-1:0] d_cand, d_res; logic [31:0] d_cnt;
  logic a_valid, a_busy, a_done, a_find; logic [BW-1:0] a_cand, a_res; logic [31:0] a_cnt;
  logic b_valid, b_busy, b_done, b_find; logic [BW-1:0] b_cand, b_res; logic [31:0] b_cnt;
  logic s_valid, s_busy, s_done, s_find; logic [BW-1:0] s_cand, s_res; logic [2:0]  s_cnt;

  md5_candidate_enum #(.N_SYMB(2), .SYMB_BASE(0), .FROM_CHAR(8'h61), .TO_CHAR(8'h63),
                       .NUM_LANES(1), .LANE_ID(0), .CNT_W(32)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .start_str(start_str),
    .cand_valid(m_valid), .cand_ready(cand_ready), .cand_str(m_cand), .match_in(match_in),
    .match_str(match_str), .busy(m_busy), .done(m_done), .find_str(m_find),
    .result_str(m_res), .cand_count(m_cnt));

  md5_candidate_enum u_def (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .start_str(start_str),
    .cand_valid(d_valid), .cand_ready(cand_ready), .cand_str(d_cand), .match_in(match_in),
    .match_str(match_str), .busy(d_busy), .done(d_done), .find_str(d_find),
    .result_str(d_res), .cand_count(d_cnt));

  md5_candidate_enum #(.N_SYMB(1), .FROM_CHAR(8'h61), .TO_CHAR(8'h63),
                       .NUM_LANES(2), .LANE_ID(1)) u_l1 (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .start_str(start_str),
    .cand_valid(a_valid), .cand_ready(cand_ready), .cand_str(a_cand), .match_in(match_in),
    .match_str(match_str), .busy(a_busy), .done(a_done), .find_str(a_find),
    .result_str(a_res), .cand_count(a_cnt));

  md5_candidate_enum #(.N_SYMB(1), .FROM_CHAR(8'h61), .TO_CHAR(8'h63),
                       .NUM_LANES(4), .LANE_ID(3)) u_l3 (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .start_str(start_str),
    .cand_valid(b_valid), .cand_ready(cand_ready), .cand_str(b_cand), .match_in(match_in),
    .match_str(match_str), .busy(b_busy), .done(b_done), .find_str(b_find),
    .result_str(b_res), .cand_count(b_cnt));

  md5_candidate_enum #(.N_SYMB(2), .FROM_CHAR(8'h61), .TO_CHAR(8'h63), .CNT_W(3)) u_sat (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .start_str(start_str),
    .cand_valid(s_valid), .cand_ready(cand_ready), .cand_str(s_cand), .match_in(match_in),
    .match_str(match_str), .busy(s_busy), .done(s_done), .find_str(s_find),
    .result_str(s_res), .cand_count(s_cnt));

  int n_chk = 0, n_fail = 0;

  task automatic check(input string name, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Candidate idx of a lane: digit 0 walks the lane's own characters, the
  // remaining positions count in base (to-from+1) above it.
  function automatic logic [BW-1:0] model_block(input logic [BW-1:0] tmpl, input int base,
      input int n, input int from, input int to, input int nl, input int lid, input int idx);
    logic [BW-1:0] b;
    int r, n0, rest;
    r    = to - from + 1;
    n0   = (to - from - lid) / nl + 1;
    rest = idx / n0;
    b    = tmpl;
    b[8*base +: 8] = 8'(from + lid + (idx % n0) * nl);
    for (int k = 1; k < n; k++) begin
      b[8*(base+k) +: 8] = 8'(from + rest % r);
      rest = rest / r;
    end
    return b;
  endfunction

  function automatic int model_total(input int n, input int from, input int to,
                                     input int nl, input int lid);
    int t;
    if (from + lid > to) return 0;
    t = (to - from - lid) / nl + 1;
    for (int k = 1; k < n; k++) t = t * (to - from + 1);
    return t;
  endfunction

  function automatic logic [BW-1:0] rand_block();
    logic [BW-1:0] b;
    for (int w = 0; w < BW/32; w++) b[32*w +: 32] = $urandom;
    return b;
  endfunction

  // Behavioural model of u_dut.
  typedef enum {S_IDLE, S_RUN, S_DONE, S_FOUND} ms_t;
  ms_t           mst = S_IDLE;
  int            midx = 0;
  logic [31:0]   mcnt = '0;
  logic [BW-1:0] mtmpl = '0, mres = '0;
  bit            macc;

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      mst = S_IDLE; midx = 0; mcnt = '0; mtmpl = '0; mres = '0;
    end else begin
      macc = (mst == S_RUN) && cand_ready;
      if (abort) begin
        mst = S_IDLE;
      end else if (match_in && (mst == S_RUN || mst == S_DONE)) begin
        if (macc && mcnt != '1) mcnt++;
        mst  = S_FOUND;
        mres = match_str;
      end else if (mst == S_RUN) begin
        if (macc) begin
          if (mcnt != '1) mcnt++;
          midx++;
          if (midx == model_total(2, 97, 99, 1, 0)) mst = S_DONE;
        end
      end else if (start) begin
        mtmpl = start_str; mcnt = '0; midx = 0;
        mst = (model_total(2, 97, 99, 1, 0) == 0) ? S_DONE : S_RUN;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    check("m_valid", BW'(m_valid), BW'(mst == S_RUN));
    check("m_busy",  BW'(m_busy),  BW'(mst == S_RUN));
    check("m_done",  BW'(m_done),  BW'(mst == S_DONE));
    check("m_find",  BW'(m_find),  BW'(mst == S_FOUND));
    check("m_count", BW'(m_cnt),   BW'(mcnt));
    check("m_result", m_res, mres);
    if (mst == S_RUN) check("m_cand", m_cand, model_block(mtmpl, 0, 2, 97, 99, 1, 0, midx));
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_start(input logic [BW-1:0] t);
    start_str = t; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  logic [15:0]   exp1 [9] = '{16'h6161, 16'h6162, 16'h6163, 16'h6261, 16'h6262,
                              16'h6263, 16'h6361, 16'h6362, 16'h6363};
  logic [BW-1:0] tmpl, mb, dead;
  int            guard;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    dead = {16{32'hDEADBEEF}};
    repeat (3) tick();
    check("rst_valid", BW'(d_valid), '0);
    check("rst_cand",  d_cand, '0);
    check("rst_res",   d_res, '0);
    check("rst_count", BW'(d_cnt), '0);
    check("rst_done",  BW'({d_done, d_find, d_busy}), '0);
    reset_n = 1'b1;
    tick();

    // Model pins.
    tmpl = rand_block();
    mb = model_block(tmpl, 0, 2, 97, 99, 1, 0, 5);
    check("pin_idx5", BW'(mb[15:0]), BW'(16'h6263));
    mb = model_block(tmpl, 0, 1, 97, 99, 2, 1, 0);
    check("pin_lane1", BW'(mb[7:0]), BW'(8'h62));
    check("pin_total9", BW'(model_total(2, 97, 99, 1, 0)), BW'(9));
    check("pin_empty", BW'(model_total(1, 97, 99, 4, 3)), BW'(0));

    // Full enumeration at full throughput plus lane partitioning.
    cand_ready = 1'b1;
    pulse_start(tmpl);
    for (int i = 0; i < 9; i++) begin
      check("t1_valid", BW'(m_valid), BW'(1));
      check("t1_cand",  BW'(m_cand[15:0]), BW'(exp1[i]));
      check("t1_tmpl",  BW'(m_cand[BW-1:16]), BW'(tmpl[BW-1:16]));
      if (i == 0) begin
        check("l1_valid", BW'(a_valid), BW'(1));
        check("l1_cand",  a_cand, {tmpl[BW-1:8], 8'h62});
        check("l3_done",  BW'({b_done, b_valid}), BW'(2'b10));
        check("l3_count", BW'(b_cnt), '0);
        check("def_first", BW'(d_cand[31:0]), BW'(32'h20202020));
      end
      if (i == 1) begin
        check("l1_done",  BW'({a_done, a_valid}), BW'(2'b10));
        check("l1_count", BW'(a_cnt), BW'(1));
        check("def_second", BW'(d_cand[31:0]), BW'(32'h20202021));
      end
      tick();
    end
    check("t1_done",  BW'({m_done, m_valid}), BW'(2'b10));
    check("t1_count", BW'(m_cnt), BW'(9));
    check("sat_count", BW'(s_cnt), BW'(3'h7));
    check("l3_never_valid", BW'(b_valid), '0);

    // Back-pressure on the second candidate.
    pulse_start(rand_block());
    tick();
    cand_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t2_hold_valid", BW'(m_valid), BW'(1));
      check("t2_hold_cand",  BW'(m_cand[15:0]), BW'(16'h6162));
      tick();
    end
    cand_ready = 1'b1;
    guard = 0;
    while (!m_done && guard < 30) begin tick(); guard++; end
    check("t2_done_in_time", BW'(m_done), BW'(1));
    check("t2_count", BW'(m_cnt), BW'(9));

    // Match after five accepts; a second match is ignored.
    abort = 1'b1; tick(); abort = 1'b0;
    pulse_start(rand_block());
    repeat (5) tick();
    cand_ready = 1'b0;
    match_str = dead; match_in = 1'b1;
    tick();
    match_in = 1'b0;
    check("t4_find",  BW'({d_find, d_valid, d_busy, d_done}), BW'(4'b1000));
    check("t4_res",   d_res, dead);
    check("t4_count", BW'(d_cnt), BW'(5));
    match_str = ~dead; match_in = 1'b1;
    tick();
    match_in = 1'b0;
    tick();
    check("t4_first_wins", d_res, dead);
    check("t4_find_hold", BW'(d_find), BW'(1));

    // Abort after four accepts, then restart.
    cand_ready = 1'b1;
    pulse_start(rand_block());
    repeat (4) tick();
    cand_ready = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_idle", BW'({d_valid, d_busy, d_done, d_find}), '0);
    check("t5_count", BW'(d_cnt), BW'(4));
    check("t5_res_kept", d_res, dead);
    pulse_start(rand_block());
    check("t5_restart_cand", BW'(d_cand[31:0]), BW'(32'h20202020));
    check("t5_restart_count", BW'(d_cnt), '0);
    check("t5_restart_valid", BW'(d_valid), BW'(1));

    // Asynchronous reset between edges.
    cand_ready = 1'b1;
    tick(); tick();
    #2 reset_n = 1'b0;
    #1;
    check("t6_flags", BW'({d_valid, d_busy, d_done, d_find}), '0);
    check("t6_cand",  d_cand, '0);
    check("t6_res",   d_res, '0);
    check("t6_count", BW'(d_cnt), '0);
    check("t6_main_cand", m_cand, '0);
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    check("t6_quiet", BW'({d_valid, d_busy, d_done, d_find}), '0);
    check("t6_quiet_count", BW'(d_cnt), '0);

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      start      = ($urandom_range(0, 9) == 0);
      abort      = ($urandom_range(0, 39) == 0);
      cand_ready = ($urandom_range(0, 3) != 0);
      match_in   = ($urandom_range(0, 29) == 0);
      match_str  = rand_block();
      start_str  = rand_block();
      tick();
    end
    start = 1'b0; abort = 1'b0; match_in = 1'b0; cand_ready = 1'b0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
